// File: rtl/singlecycle_pkg.sv
// ---------------------------------------------------------------------------
// singlecycle_pkg
//   Shared definitions for the single-cycle core's memory-mapped peripherals.
//   Timer block items:
//     TIMER_NUM_DEFAULT  default channel count
//     TIMER_BASE_ADDR    base byte address of the timer window
//     TMR_*_OFS          byte offsets of the per-channel registers
//     CTRL_*_BIT         bit positions inside CTRL
//     TimerCtrl_s        packed view of the CTRL register
//     ctrl_to_word()     zero-extends a TimerCtrl_s to a 32-bit read word
// ---------------------------------------------------------------------------
package singlecycle_pkg;

    localparam int          TIMER_NUM_DEFAULT = 4;
    localparam logic [31:0] TIMER_BASE_ADDR   = 32'h0000_4000;

    // Per-channel register byte offsets (each channel spans 16 bytes)
    localparam logic [3:0] TMR_CTRL_OFS  = 4'h0;
    localparam logic [3:0] TMR_LOAD_OFS  = 4'h4;
    localparam logic [3:0] TMR_COUNT_OFS = 4'h8;
    localparam logic [3:0] TMR_STAT_OFS  = 4'hC;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS bit positions
    localparam int STAT_EXP_BIT = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } TimerCtrl_s;

    function automatic logic [31:0] ctrl_to_word(input TimerCtrl_s c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]     = c.en;
        w[CTRL_AUTO_BIT]   = c.auto_reload;
        w[CTRL_IRQ_EN_BIT] = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/lsu_timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
//   One 32-bit down-counting timer: CTRL, LOAD, COUNT and a sticky EXP flag.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     tick            shared prescaler tick (one-cycle pulse)
//     wr_ctrl/load/count/stat  decoded store strobes for this channel
//     wdata           store data
//     ctrl            current CTRL fields
//     load_val        current LOAD value
//     count           current COUNT value
//     exp             current STATUS.EXP flag
// ---------------------------------------------------------------------------
module timer_channel
    import singlecycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        wr_ctrl,
    input  logic        wr_load,
    input  logic        wr_count,
    input  logic        wr_stat,
    input  logic [31:0] wdata,
    output logic [2:0]  ctrl,
    output logic [31:0] load_val,
    output logic [31:0] count,
    output logic        exp
);

    TimerCtrl_s  ctrl_reg,  ctrl_next;
    logic [31:0] load_reg,  load_next;
    logic [31:0] count_reg, count_next;
    logic        exp_reg,   exp_next;

    logic fire;
    logic at_zero;

    assign fire    = ctrl_reg.en & tick;
    assign at_zero = (count_reg == 32'd0);

    // Priority is expressed by statement order: later assignments win.
    //   1. W1C of EXP
    //   2. hardware tick events (decrement / expire / reload / EN clear)
    //   3. software CTRL and COUNT stores
    // so an expiry beats a same-cycle W1C, while software stores beat the
    // hardware COUNT update and the hardware EN clear.
    always_comb begin
        ctrl_next  = ctrl_reg;
        load_next  = load_reg;
        count_next = count_reg;
        exp_next   = exp_reg;

        if (wr_stat && wdata[STAT_EXP_BIT]) begin
            exp_next = 1'b0;
        end

        if (fire) begin
            if (!at_zero) begin
                count_next = count_reg - 32'd1;
            end else begin
                exp_next = 1'b1;
                if (ctrl_reg.auto_reload) begin
                    count_next = load_reg;
                end else begin
                    ctrl_next.en = 1'b0;
                end
            end
        end

        if (wr_load) begin
            load_next = wdata;
        end
        if (wr_count) begin
            count_next = wdata;
        end
        if (wr_ctrl) begin
            ctrl_next.en          = wdata[CTRL_EN_BIT];
            ctrl_next.auto_reload = wdata[CTRL_AUTO_BIT];
            ctrl_next.irq_en      = wdata[CTRL_IRQ_EN_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg  <= '0;
            load_reg  <= '0;
            count_reg <= '0;
            exp_reg   <= 1'b0;
        end else begin
            ctrl_reg  <= ctrl_next;
            load_reg  <= load_next;
            count_reg <= count_next;
            exp_reg   <= exp_next;
        end
    end

    assign ctrl     = ctrl_reg;
    assign load_val = load_reg;
    assign count    = count_reg;
    assign exp      = exp_reg;

endmodule

// File: rtl/lsu_timer.sv
// ---------------------------------------------------------------------------
// lsu_timer
//   LSU-facing memory-mapped timer block at TIMER_BASE_ADDR. TIMER_NUM
//   down-counting channels share one prescaler; loads return one cycle later.
//   Parameters:
//     TIMER_NUM  channel count (power of two, >= 2), 16 bytes per channel
//     PRESC_DIV  clock cycles per count tick, 1..65535
//   Ports:
//     i_clk, i_rst_n  clock, synchronous active-low reset
//     i_lsu_valid     request valid
//     i_lsu_addr      byte address (word accesses, [1:0] ignored)
//     i_st_en         1 = store, 0 = load
//     i_st_data       store data
//     o_ld_data       registered load data, held until the next load
//     o_ld_valid      one-cycle pulse the cycle after a load
//     o_irq           OR over channels of EXP & IRQ_EN
// ---------------------------------------------------------------------------
module lsu_timer
    import singlecycle_pkg::*;
#(
    parameter int TIMER_NUM = TIMER_NUM_DEFAULT,
    parameter int PRESC_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lsu_valid,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_st_en,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_irq
);

    localparam int          CH_W      = $clog2(TIMER_NUM);
    localparam int          ADDR_LO   = 4 + CH_W;
    localparam logic [15:0] PRESC_MAX = 16'(PRESC_DIV - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            hit;
    logic [CH_W-1:0] ch_sel;
    logic [3:0]      reg_ofs;
    logic            st_hit;
    logic            ld_req;

    assign hit     = (i_lsu_addr[31:ADDR_LO] == TIMER_BASE_ADDR[31:ADDR_LO]);
    assign ch_sel  = i_lsu_addr[4 +: CH_W];
    assign reg_ofs = {i_lsu_addr[3:2], 2'b00};
    assign st_hit  = i_lsu_valid & i_st_en & hit;
    assign ld_req  = i_lsu_valid & ~i_st_en;

    // Byte lane bits carry no meaning for word-only accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_lsu_addr[1:0];

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [15:0] presc_reg, presc_next;
    logic        tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_comb begin
        presc_next = tick ? 16'd0 : presc_reg + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [2:0]  ch_ctrl  [TIMER_NUM];
    logic [31:0] ch_load  [TIMER_NUM];
    logic [31:0] ch_count [TIMER_NUM];
    logic        ch_exp   [TIMER_NUM];
    logic [TIMER_NUM-1:0] irq_vec;

    genvar gi;
    generate
        for (gi = 0; gi < TIMER_NUM; gi++) begin : g_ch
            logic sel;
            assign sel = st_hit & (ch_sel == CH_W'(gi));

            timer_channel u_ch (
                .clk      (i_clk),
                .rst_n    (i_rst_n),
                .tick     (tick),
                .wr_ctrl  (sel & (reg_ofs == TMR_CTRL_OFS)),
                .wr_load  (sel & (reg_ofs == TMR_LOAD_OFS)),
                .wr_count (sel & (reg_ofs == TMR_COUNT_OFS)),
                .wr_stat  (sel & (reg_ofs == TMR_STAT_OFS)),
                .wdata    (i_st_data),
                .ctrl     (ch_ctrl[gi]),
                .load_val (ch_load[gi]),
                .count    (ch_count[gi]),
                .exp      (ch_exp[gi])
            );

            assign irq_vec[gi] = ch_exp[gi] & ch_ctrl[gi][CTRL_IRQ_EN_BIT];
        end
    endgenerate

    // Registered state only, so no request-to-irq path exists.
    assign o_irq = |irq_vec;

    // ------------------------------------------------------------------
    // Read mux and load response
    // ------------------------------------------------------------------
    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (reg_ofs)
                TMR_CTRL_OFS:  rd_word = ctrl_to_word(TimerCtrl_s'(ch_ctrl[ch_sel]));
                TMR_LOAD_OFS:  rd_word = ch_load[ch_sel];
                TMR_COUNT_OFS: rd_word = ch_count[ch_sel];
                TMR_STAT_OFS:  rd_word = {31'd0, ch_exp[ch_sel]};
                default:       rd_word = '0;
            endcase
        end
    end

    logic [31:0] ld_data_reg;
    logic        ld_valid_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ld_data_reg  <= '0;
            ld_valid_reg <= 1'b0;
        end else begin
            ld_valid_reg <= ld_req;
            if (ld_req) begin
                ld_data_reg <= rd_word;
            end
        end
    end

    assign o_ld_data  = ld_data_reg;
    assign o_ld_valid = ld_valid_reg;

endmodule
